// File: rtl/mcs_io_sequencer.sv
// Converts the MicroBlaze MCS strobe IO bus into the registered single-transaction
// signal set consumed by the FPro MCS bridge (rw pulse, byte enables, word address, data).
module mcs_io_sequencer #(
  parameter int RD_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_addr_strobe,
  input  logic        io_read_strobe,
  input  logic        io_write_strobe,
  input  logic [31:0] io_address,
  input  logic [3:0]  io_byte_enable,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  output logic        io_ready,
  output logic        br_rw,
  output logic [3:0]  br_byte_enable,
  output logic [29:0] br_address,
  output logic [31:0] br_write_data,
  input  logic [31:0] br_read_data,
  output logic        seq_overrun
);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    DONE
  } state_t;

  localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);

  state_t      state;
  state_t      state_next;
  logic [3:0]  wait_cnt;
  logic        accept_wr;
  logic        accept_rd;
  logic        rd_sample;
  logic        unused_addr_bits;

  // Byte offset is meaningless to the word-addressed bridge.
  assign unused_addr_bits = ^io_address[1:0];

  // Write wins over read when both strobes arrive together.
  assign accept_wr = (state == IDLE) && io_addr_strobe && io_write_strobe;
  assign accept_rd = (state == IDLE) && io_addr_strobe && io_read_strobe && !io_write_strobe;
  assign rd_sample = (state == RD) && (wait_cnt == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    br_rw      = 1'b0;
    io_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (accept_wr) begin
          state_next = WR;
        end else if (accept_rd) begin
          state_next = RD;
        end
      end
      WR: begin
        br_rw      = 1'b1;
        state_next = DONE;
      end
      RD: begin
        if (rd_sample) begin
          state_next = DONE;
        end
      end
      DONE: begin
        io_ready   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bridge-side request registers hold until the next accepted strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_address     <= '0;
      br_byte_enable <= '0;
      br_write_data  <= '0;
    end else begin
      if (accept_wr || accept_rd) begin
        br_address     <= io_address[31:2];
        br_byte_enable <= io_byte_enable;
      end
      if (accept_wr) begin
        br_write_data <= io_write_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (accept_rd) begin
      wait_cnt <= RD_LOAD;
    end else if ((state == RD) && (wait_cnt != 4'd0)) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_read_data <= '0;
    end else if (rd_sample) begin
      io_read_data <= br_read_data;
    end
  end

  // Any strobe seen outside IDLE is dropped; remember that it happened.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_overrun <= 1'b0;
    end else if (io_addr_strobe && (state != IDLE)) begin
      seq_overrun <= 1'b1;
    end
  end

endmodule
